rf_wr_arbiter: RTL
==================

# rf_wr_arbiter

Arbiter for the single register-file write port, sitting between the write-back stage and the register file. The in-order WB path always has priority. Results from long-latency units (mul/div, late CP0 reads) are queued in a small FIFO and drained on cycles when WB does not write. The block also reports pending-destination hazards to decode and can request a one-bubble stall to prevent starvation of the queued results.

## Interface

Parameters:
- `DEPTH`, default 2: aux FIFO entries; a power of two, ≥ 2.
- `STARVE_LIMIT`, default 8: number of consecutive blocked cycles before `stall_req` is raised (range 1–255).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb_we`  in  1  WB stage write request; always granted.
- `wb_addr`  in  5  WB destination register.
- `wb_data`  in  32  WB write data.
- `aux_valid`  in  1  long-latency result valid.
- `aux_addr`  in  5  long-latency destination register.
- `aux_data`  in  32  long-latency result.
- `aux_ready`  out  1  FIFO can accept an entry; `(count < DEPTH)`, driven from registered count.
- `chk_addr`  in  5  decode source-register query.
- `chk_hit`  out  1  combinational; high if any valid FIFO entry has `addr == chk_addr` and `chk_addr != 0`.
- `stall_req`  out  1  registered request to the pipeline to insert a WB bubble.
- `rf_we`  out  1  register-file write enable (registered).
- `rf_waddr`  out  5  register-file write address (registered).
- `rf_wdata`  out  32  register-file write data (registered).

## Operation

- **Aux push:** occurs when `aux_valid && aux_ready`. Push is refused when the FIFO is full, even if a pop happens in the same cycle.
- **Aux push discard:** the entry is dropped (handshake still completes) if either:
  - `aux_addr == 0`, or
  - `wb_we && wb_addr == aux_addr` in the same cycle (WB is younger and wins the WAW).
- **WAW cancel:** when `wb_we` is high and `wb_addr != 0`, every valid FIFO entry with a matching address is invalidated. Invalidated entries stay in their slots and are skipped at pop with no write (a pop slot is consumed, but `rf_we` stays 0 for that cycle).
- **Grant rules, per cycle:**
  - `wb_we && wb_addr != 0`: grant WB.
  - Otherwise, if the FIFO is non-empty: pop the head; write it if the head is valid.
  - Otherwise: no write.
  - `wb_we` with `wb_addr == 0` counts as no WB write, so the FIFO may drain that cycle.
- **Simultaneous events:**
  - Push and pop in the same cycle: count is unchanged.
  - Push into an empty FIFO is not poppable until the next cycle.
- **Pointers:** read and write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. Count is `log2(DEPTH)+1` bits.
- **Starvation counter** (8 bits, saturating):
  - Increments on each cycle where the FIFO is non-empty and WB took the port.
  - Clears on any pop or when the FIFO is empty.
- **`stall_req`:**
  - Set on the edge after the counter reaches `STARVE_LIMIT`.
  - Cleared on the edge after the next pop.
- **Pipeline responsibility:** the pipeline gates `wb_we` low while `stall_req` is high. If it does not, WB still wins.
- **Reset mid-operation:** the FIFO contents are lost, all pointers, the count and the counter clear, and outputs return to their reset values.

## Timing

- **Reset values:**
  - `rf_we`, `rf_waddr`, `rf_wdata`, `stall_req` = 0.
  - `aux_ready` = 1.
  - `chk_hit` = 0 for any `chk_addr`.
- **WB latency:** `wb_*` sampled on cycle N appears on `rf_*` in cycle N+1.
- **Aux latency:** an entry pushed in cycle N is popped no earlier than N+1 and is visible on `rf_*` no earlier than N+2.
- **`chk_hit`:**
  - Reflects FIFO state after the most recent edge.
  - Goes high the cycle after the push.
  - Goes low the cycle after the pop or cancel.
- **`aux_ready`** deasserts the cycle after the push that fills the FIFO.

## Configuration

- **`RF_ARB_STARVE_GUARD_EN` defined:** the starvation counter and `stall_req` operate as described.
- **`RF_ARB_STARVE_GUARD_EN` undefined:**
  - No counter logic is compiled in, and `stall_req` is tied to 0.
  - Aux entries drain only on WB-idle cycles; they can wait indefinitely.

## Test plan

- **Single aux, no WB:** reset; push `aux` r3=`0x12345678` with `wb_we=0` -> `rf_we=1`, `rf_waddr=3`, `rf_wdata=0x12345678` exactly 2 cycles after the push; `chk_hit` for `chk_addr=3` is high for exactly 1 cycle.
- **WB priority and full FIFO** (DEPTH=2):
  - Push r4 and r5 while `wb_we=1`, r7 = `0xAAAA0000` every cycle -> `aux_ready=0` after the second push; `rf` shows only r7 writes.
  - Drop `wb_we` -> r4 then r5 appear on consecutive cycles, then `aux_ready=1`.
- **WAW cancel:** queue r9=1; next cycle WB writes r9=2 -> exactly one `rf` write to r9 (value 2); the cancelled slot pops with `rf_we=0`; `chk_hit(9)` goes low the cycle after the WB write.
- **Zero-register discard:** push `aux` to r0, and drive WB `wb_we=1` to r0 -> no `rf_we`; FIFO stays empty; `aux_ready` stays 1.
- **Starvation** (macro defined, `STARVE_LIMIT=4`): queue r6 and hold `wb_we=1` -> `stall_req` rises after 4 blocked cycles; bench then drops `wb_we` -> r6 written and `stall_req` falls the cycle after the pop. With the macro undefined -> `stall_req` stays 0.
- **Async reset:** assert `rst_n=0` mid-drain with 2 entries queued -> all outputs go to reset values immediately; after release, no stale write appears and `aux_ready=1`.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: WB always wins, long-latency results queue and drain on idle WB cycles.
// Build option: define RF_ARB_STARVE_GUARD_EN to enable the starvation counter and stall_req.
module rf_wr_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        aux_valid,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    input  logic [4:0]  chk_addr,
    output logic        chk_hit,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0][4:0]  addr_q, addr_d;
    logic [DEPTH-1:0][31:0] data_q, data_d;
    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;

    logic wb_grant;
    logic fifo_empty;
    logic pop;
    logic push;
    logic push_drop;
    logic hit_any;

    assign aux_ready = (count_q < DEPTH_C);
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;

    // A WB write to r0 is not a real write, so the queue may drain that cycle.
    always_comb begin
        wb_grant   = wb_we && (wb_addr != 5'd0);
        fifo_empty = (count_q == '0);
        pop        = !wb_grant && !fifo_empty;
        push_drop  = (aux_addr == 5'd0) || (wb_we && (wb_addr == aux_addr));
        push       = aux_valid && aux_ready && !push_drop;
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        vld_d  = vld_q;
        // WB is younger than anything queued: kill older results to the same register.
        if (wb_grant) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && (addr_q[i] == wb_addr)) begin
                    vld_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            addr_d[wr_ptr_q] = aux_addr;
            data_d[wr_ptr_q] = aux_data;
            vld_d[wr_ptr_q]  = 1'b1;
        end
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        if (wb_grant) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_addr;
            rf_wdata_d = wb_data;
        end else if (pop && vld_q[rd_ptr_q]) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = addr_q[rd_ptr_q];
            rf_wdata_d = data_q[rd_ptr_q];
        end
    end

    always_comb begin
        hit_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == chk_addr)) begin
                hit_any = 1'b1;
            end
        end
        chk_hit = hit_any && (chk_addr != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            data_q     <= '0;
            vld_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

    logic [7:0] starve_q, starve_d;
    logic       stall_q, stall_d;

    assign stall_req = stall_q;

    // Counts cycles where WB took the port while something was waiting; saturates.
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (wb_grant && (starve_q != 8'hFF)) begin
            starve_d = starve_q + 8'd1;
        end
        stall_d = stall_q;
        if (pop) begin
            stall_d = 1'b0;
        end else if (starve_d >= LIMIT_C) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end
`else
    logic unused_starve_cfg;

    assign unused_starve_cfg = (STARVE_LIMIT > 0);
    assign stall_req         = 1'b0;
`endif

endmodule
